// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - Pipeline-side signal bundle between the IF/ID/EX stages and pc_unit
interface pc_unit_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             id_jump;
    logic [25:0]      id_instr_index;
    logic [WIDTH-1:0] id_pc;
    logic             ex_branch;
    logic             ex_bne;
    logic             ex_zero;
    logic             ex_pred;
    logic [WIDTH-1:0] ex_pc;
    logic [15:0]      ex_imm16;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic             pred_taken;
    logic             flush_id;
    logic             flush_ex;

    modport master (
        output stall, id_jump, id_instr_index, id_pc,
        output ex_branch, ex_bne, ex_zero, ex_pred, ex_pc, ex_imm16,
        input  pc, pc_plus4, pred_taken, flush_id, flush_ex
    );

    modport slave (
        input  stall, id_jump, id_instr_index, id_pc,
        input  ex_branch, ex_bne, ex_zero, ex_pred, ex_pc, ex_imm16,
        output pc, pc_plus4, pred_taken, flush_id, flush_ex
    );
endinterface

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - Registered IF-stage PC with mispredict/jump/stall/BTB next-PC priority and flush outputs
// Optional direct-mapped branch target buffer is compiled in with `define PC_BTB_EN.
module pc_unit #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int               BTB_DEPTH = 16
) (
    input logic      clk,
    input logic      rst_n,
    pc_unit_if.slave bus
);
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] ex_pc_plus4;
    logic [WIDTH-1:0] br_offset;
    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] redirect_pc;
    logic [WIDTH-1:0] id_pc_plus4;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] btb_target;
    logic             taken;
    logic             mispredict;
    logic             jump_go;
    logic             pred_hit;
    logic             unused_bits;

    assign seq_pc      = pc_q + WIDTH'(4);
    assign ex_pc_plus4 = bus.ex_pc + WIDTH'(4);
    assign br_offset   = {{(WIDTH-18){bus.ex_imm16[15]}}, bus.ex_imm16, 2'b00};
    assign br_target   = ex_pc_plus4 + br_offset;
    assign taken       = bus.ex_branch & (bus.ex_zero ^ bus.ex_bne);
    assign mispredict  = bus.ex_branch & (taken != bus.ex_pred);
    assign redirect_pc = taken ? br_target : ex_pc_plus4;
    assign jump_go     = bus.id_jump & ~bus.stall;
    assign id_pc_plus4 = bus.id_pc + WIDTH'(4);

    // The jump keeps the region bits of the delay-slot PC; at WIDTH=28 there are none.
    generate
        if (WIDTH > 28) begin : g_jump_region
            assign jump_target = {id_pc_plus4[WIDTH-1:28], bus.id_instr_index, 2'b00};
        end else begin : g_jump_flat
            assign jump_target = {bus.id_instr_index, 2'b00};
        end
    endgenerate

    assign unused_bits = ^{id_pc_plus4[27:0], pc_d[1:0]};

`ifdef PC_BTB_EN
    localparam int IDXW = (BTB_DEPTH > 1) ? $clog2(BTB_DEPTH) : 1;
    localparam int TAGW = WIDTH - IDXW - 2;

    logic [BTB_DEPTH-1:0] btb_valid_q;
    logic [TAGW-1:0]      btb_tag_q [BTB_DEPTH];
    logic [WIDTH-1:0]     btb_tgt_q [BTB_DEPTH];
    logic [1:0]           btb_cnt_q [BTB_DEPTH];
    logic [IDXW-1:0]      rd_idx;
    logic [IDXW-1:0]      wr_idx;
    logic [TAGW-1:0]      wr_tag;
    logic                 rd_hit;
    logic                 wr_hit;
    logic                 wr_en;
    logic [1:0]           wr_cnt;

    assign rd_idx     = pc_q[IDXW+1:2];
    assign rd_hit     = btb_valid_q[rd_idx] && (btb_tag_q[rd_idx] == pc_q[WIDTH-1:IDXW+2]);
    assign pred_hit   = rd_hit & btb_cnt_q[rd_idx][1];
    assign btb_target = btb_tgt_q[rd_idx];
    assign wr_idx     = bus.ex_pc[IDXW+1:2];
    assign wr_tag     = bus.ex_pc[WIDTH-1:IDXW+2];
    assign wr_hit     = btb_valid_q[wr_idx] && (btb_tag_q[wr_idx] == wr_tag);

    always_comb begin
        wr_en  = 1'b0;
        wr_cnt = 2'b10;
        if (bus.ex_branch) begin
            if (wr_hit) begin
                wr_en = 1'b1;
                if (taken) begin
                    wr_cnt = (btb_cnt_q[wr_idx] == 2'b11) ? 2'b11 : btb_cnt_q[wr_idx] + 2'b01;
                end else begin
                    wr_cnt = (btb_cnt_q[wr_idx] == 2'b00) ? 2'b00 : btb_cnt_q[wr_idx] - 2'b01;
                end
            end else if (taken) begin
                wr_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btb_valid_q <= '0;
        end else if (wr_en) begin
            btb_valid_q[wr_idx] <= 1'b1;
        end
    end

    // Entry payload needs no reset: it is only read behind a valid bit.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            btb_tag_q[wr_idx] <= wr_tag;
            btb_tgt_q[wr_idx] <= br_target;
            btb_cnt_q[wr_idx] <= wr_cnt;
        end
    end
`else
    localparam int UNUSED_BTB_DEPTH = BTB_DEPTH;

    assign pred_hit   = 1'b0;
    assign btb_target = '0;
`endif

    always_comb begin
        pc_d = seq_pc;
        if (mispredict) begin
            pc_d = redirect_pc;
        end else if (jump_go) begin
            pc_d = jump_target;
        end else if (bus.stall) begin
            pc_d = pc_q;
        end else if (pred_hit) begin
            pc_d = btb_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= {RESET_PC[WIDTH-1:2], 2'b00};
        end else begin
            pc_q <= {pc_d[WIDTH-1:2], 2'b00};
        end
    end

    assign bus.pc         = pc_q;
    assign bus.pc_plus4   = seq_pc;
    assign bus.pred_taken = rst_n & pred_hit;
    assign bus.flush_id   = rst_n & (mispredict | jump_go);
    assign bus.flush_ex   = rst_n & mispredict;
endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - Directed bench for pc_unit with a cycle-level reference model
module tb_pc_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          DEPTH    = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    pc_unit_if #(.WIDTH(32)) bus ();

    pc_unit #(
        .WIDTH    (32),
        .RESET_PC (RESET_PC),
        .BTB_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: BTB entries remember the full branch PC, which is equivalent to index+tag.
    bit          live;
    logic [31:0] m_pc;
    logic [31:0] m_nxt;
    bit          m_valid [DEPTH];
    logic [31:0] m_bpc   [DEPTH];
    logic [31:0] m_btgt  [DEPTH];
    int          m_cnt   [DEPTH];
    bit          upd_en;
    int          upd_i;
    logic [31:0] upd_bpc;
    logic [31:0] upd_tgt;
    int          upd_cnt;

    always @(negedge clk) begin : model_cmp
        int          i;
        int          j;
        int          off;
        int          c;
        bit          pt;
        bit          tk;
        bit          mis;
        bit          jmp;
        logic [31:0] tgt;
        logic [31:0] red;
        logic [31:0] jt;
        logic [31:0] nx;
        if (live) begin
            i = int'((m_pc >> 2) % DEPTH);
`ifdef PC_BTB_EN
            pt = m_valid[i] && (m_bpc[i] == m_pc) && (m_cnt[i] >= 2);
`else
            pt = 1'b0;
`endif
            tk  = bus.ex_branch && (bus.ex_zero != bus.ex_bne);
            off = $signed(bus.ex_imm16);
            tgt = bus.ex_pc + 32'd4 + 32'(off * 4);
            mis = bus.ex_branch && (tk != bus.ex_pred);
            jmp = bus.id_jump && !bus.stall;
            red = tk ? tgt : bus.ex_pc + 32'd4;
            jt  = ((bus.id_pc + 32'd4) & 32'hF000_0000) | (32'(bus.id_instr_index) * 4);

            chk("m_pc", bus.pc, m_pc);
            chk("m_pc_plus4", bus.pc_plus4, m_pc + 32'd4);
            chk("m_pred_taken", 32'(bus.pred_taken), rst_n ? 32'(pt) : 32'd0);
            chk("m_flush_id", 32'(bus.flush_id), rst_n ? 32'(mis || jmp) : 32'd0);
            chk("m_flush_ex", 32'(bus.flush_ex), rst_n ? 32'(mis) : 32'd0);

            if (mis)            nx = red;
            else if (jmp)       nx = jt;
            else if (bus.stall) nx = m_pc;
            else if (pt)        nx = m_btgt[i];
            else                nx = m_pc + 32'd4;
            m_nxt <= nx;

            j = int'((bus.ex_pc >> 2) % DEPTH);
            c = 2;
            upd_en <= 1'b0;
            if (rst_n && bus.ex_branch) begin
                if (m_valid[j] && m_bpc[j] == bus.ex_pc) begin
                    c = tk ? ((m_cnt[j] == 3) ? 3 : m_cnt[j] + 1) : ((m_cnt[j] == 0) ? 0 : m_cnt[j] - 1);
                    upd_en <= 1'b1;
                end else if (tk) begin
                    upd_en <= 1'b1;
                end
            end
            upd_i   <= j;
            upd_bpc <= bus.ex_pc;
            upd_tgt <= tgt;
            upd_cnt <= c;
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            live <= 1'b1;
            m_pc <= RESET_PC;
            for (int k = 0; k < DEPTH; k++) m_valid[k] <= 1'b0;
        end else if (live) begin
            m_pc <= m_nxt;
            if (upd_en) begin
                m_valid[upd_i] <= 1'b1;
                m_bpc[upd_i]   <= upd_bpc;
                m_btgt[upd_i]  <= upd_tgt;
                m_cnt[upd_i]   <= upd_cnt;
            end
        end
    end

    initial begin
        checks             = 0;
        errors             = 0;
        live               = 1'b0;
        upd_en             = 1'b0;
        rst_n              = 1'b0;
        bus.stall          = 1'b0;
        bus.id_jump        = 1'b0;
        bus.id_instr_index = 26'h0;
        bus.id_pc          = 32'h0;
        bus.ex_branch      = 1'b1;
        bus.ex_bne         = 1'b0;
        bus.ex_zero        = 1'b1;
        bus.ex_pred        = 1'b0;
        bus.ex_pc          = 32'h20;
        bus.ex_imm16       = 16'h0;

        // Reset with a taken, unpredicted branch pending
        step();
        chk("rst_pc_a", bus.pc, 32'h100);
        chk("rst_flush_id", 32'(bus.flush_id), 32'd0);
        chk("rst_flush_ex", 32'(bus.flush_ex), 32'd0);
        step();
        chk("rst_pc_b", bus.pc, 32'h100);
        rst_n         = 1'b1;
        bus.ex_branch = 1'b0;
        #1;
        chk("rel_pc", bus.pc, 32'h100);
        step();
        chk("rel_pc_next", bus.pc, 32'h104);

        // Redirect to 0x0, then sequential run and stall
        bus.ex_branch = 1'b1;
        bus.ex_pc     = 32'h10;
        bus.ex_imm16  = 16'hFFFB;
        #1;
        chk("to0_flush_id", 32'(bus.flush_id), 32'd1);
        chk("to0_flush_ex", 32'(bus.flush_ex), 32'd1);
        step();
        bus.ex_branch = 1'b0;
        chk("seq_0", bus.pc, 32'h0);
        step();
        chk("seq_4", bus.pc, 32'h4);
        step();
        chk("seq_8", bus.pc, 32'h8);
        bus.stall = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step();
            chk("stall_hold", bus.pc, 32'h8);
        end
        bus.stall = 1'b0;
        step();
        chk("stall_release", bus.pc, 32'hC);

        // BEQ taken backwards, then the same as BNE
        bus.ex_branch = 1'b1;
        bus.ex_pc     = 32'h20;
        bus.ex_imm16  = 16'hFFFC;
        bus.ex_zero   = 1'b1;
        bus.ex_pred   = 1'b0;
        #1;
        chk("beq_flush_id", 32'(bus.flush_id), 32'd1);
        chk("beq_flush_ex", 32'(bus.flush_ex), 32'd1);
        step();
        chk("beq_pc", bus.pc, 32'h14);
        bus.ex_bne = 1'b1;
        #1;
        chk("bne_flush_id", 32'(bus.flush_id), 32'd0);
        chk("bne_flush_ex", 32'(bus.flush_ex), 32'd0);
        step();
        chk("bne_pc", bus.pc, 32'h18);
        bus.ex_bne = 1'b0;

        // Mispredict beats jump and stall
        bus.ex_pc          = 32'h1FC;
        bus.ex_imm16       = 16'h0;
        bus.id_jump        = 1'b1;
        bus.id_instr_index = 26'h40;
        bus.id_pc          = 32'h30;
        bus.stall          = 1'b1;
        step();
        chk("prio_pc", bus.pc, 32'h200);
        bus.ex_branch = 1'b0;
        bus.stall     = 1'b0;
        #1;
        chk("jmp_flush_id", 32'(bus.flush_id), 32'd1);
        chk("jmp_flush_ex", 32'(bus.flush_ex), 32'd0);
        step();
        chk("jmp_pc", bus.pc, 32'h100);
        bus.stall = 1'b1;
        #1;
        chk("jmp_stall_flush", 32'(bus.flush_id), 32'd0);
        step();
        chk("jmp_stall_hold", bus.pc, 32'h100);
        bus.stall = 1'b0;
        step();
        chk("jmp_after_stall", bus.pc, 32'h100);
        bus.id_pc          = 32'h1FFF_FFFC;
        bus.id_instr_index = 26'h10;
        step();
        chk("jmp_region_carry", bus.pc, 32'h2000_0040);
        bus.id_jump = 1'b0;

        // Branch target wraps past the top of the address space
        bus.ex_branch = 1'b1;
        bus.ex_pc     = 32'hFFFF_FFF8;
        bus.ex_imm16  = 16'h0001;
        step();
        chk("wrap_pc", bus.pc, 32'h0);

        // BTB training sequence on a branch at 0x40 targeting 0x80
        bus.ex_pc    = 32'h40;
        bus.ex_imm16 = 16'h000F;
        #1;
        chk("btb_train_flush", 32'(bus.flush_ex), 32'd1);
        step();
        chk("btb_train_pc", bus.pc, 32'h80);
        bus.ex_branch      = 1'b0;
        bus.id_jump        = 1'b1;
        bus.id_pc          = 32'h0;
        bus.id_instr_index = 26'h10;
        step();
        chk("btb_refetch", bus.pc, 32'h40);
        bus.id_jump = 1'b0;
        #1;
`ifdef PC_BTB_EN
        chk("btb_pred_1", 32'(bus.pred_taken), 32'd1);
        step();
        chk("btb_follow", bus.pc, 32'h80);
`else
        chk("btb_pred_1", 32'(bus.pred_taken), 32'd0);
        step();
        chk("btb_follow", bus.pc, 32'h44);
`endif
        bus.ex_branch = 1'b1;
        bus.ex_zero   = 1'b0;
        bus.ex_pred   = 1'b1;
        #1;
        chk("btb_nt_flush", 32'(bus.flush_ex), 32'd1);
        step();
        chk("btb_nt_pc", bus.pc, 32'h44);
        bus.ex_branch = 1'b0;
        bus.ex_pred   = 1'b0;
        bus.id_jump   = 1'b1;
        step();
        chk("btb_refetch2", bus.pc, 32'h40);
        bus.id_jump = 1'b0;
        #1;
        chk("btb_pred_0", 32'(bus.pred_taken), 32'd0);
        step();
        chk("btb_seq", bus.pc, 32'h44);
        bus.ex_branch = 1'b1;
        bus.ex_zero   = 1'b1;
        #1;
        chk("taken_flush", 32'(bus.flush_ex), 32'd1);
        step();
        chk("taken_pc", bus.pc, 32'h80);
        bus.ex_branch = 1'b0;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
# pc_unit

Registered program-counter unit for the pipelined MIPS core, replacing the combinational next-PC logic of the single-cycle datapath. It holds the IF-stage PC and selects the next fetch address among sequential, ID-stage jump, EX-stage branch resolution and an optional direct-mapped branch target buffer (BTB). It handles stall and redirect priority, and drives the pipeline flush signals.

## Interface
- WIDTH, 32, PC width; legal range 28..32.
- RESET_PC, 0, PC value loaded on reset; must be word-aligned.
- BTB_DEPTH, 16, number of BTB entries; power of two ≥ 2; ignored when the BTB is compiled out.

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- stall  in  1  hold PC (load-use hazard)
- id_jump  in  1  J/JAL decoded in ID
- id_instr_index  in  26  instr[25:0] of the ID instruction
- id_pc  in  WIDTH  PC of the ID instruction
- ex_branch  in  1  BEQ/BNE in EX, valid this cycle
- ex_bne  in  1  branch is BNE
- ex_zero  in  1  ALU zero flag
- ex_pred  in  1  pred_taken value carried down with the EX branch
- ex_pc  in  WIDTH  PC of the EX branch
- ex_imm16  in  16  branch offset field
- pc  out  WIDTH  current fetch address (registered)
- pc_plus4  out  WIDTH  pc+4 (combinational)
- pred_taken  out  1  BTB predicts taken for pc
- flush_id  out  1  squash the IF/ID register
- flush_ex  out  1  squash the ID/EX register

## Operation
- Branch resolution:
  - taken = ex_branch & (ex_zero ^ ex_bne).
  - target = ex_pc + 4 + (sign_extend(ex_imm16) << 2), computed modulo 2^WIDTH.
  - mispredict = ex_branch & (taken ≠ ex_pred).
  - Redirect address on mispredict: target if taken, else ex_pc + 4.
- Jump target = {(id_pc+4)[WIDTH-1:28], id_instr_index, 2'b00}. The upper field is absent when WIDTH = 28.
- Next-PC priority, highest first:
  1. mispredict → redirect address. Overrides stall.
  2. id_jump & !stall → jump target. id_jump is ignored while stalled; the jump redirects once the stall drops.
  3. stall → hold pc.
  4. pred_taken → BTB target.
  5. Otherwise → pc_plus4.
- Flush signals:
  - flush_id = mispredict | (id_jump & !stall).
  - flush_ex = mispredict.
- All arithmetic wraps modulo 2^WIDTH. pc[1:0] is always 0.

## Timing
- pc updates on the rising clk edge. pc_plus4, pred_taken, flush_id and flush_ex are combinational from the current pc and inputs.
- Redirect latency: the branch/jump event is presented in cycle N; pc equals the new address in cycle N+1.
- While rst_n = 0:
  - pc ← RESET_PC on each edge.
  - All BTB valid bits are cleared.
  - pred_taken, flush_id and flush_ex are forced to 0.
- Reset wins over all other inputs, including a simultaneous mispredict.
- The first cycle after release fetches RESET_PC.

## Configuration
- PC_BTB_EN defined:
  - Direct-mapped BTB with BTB_DEPTH entries, indexed by pc[log2(BTB_DEPTH)+1:2]. Each entry holds valid, tag (remaining upper PC bits), target and a 2-bit saturating counter.
  - pred_taken = hit & counter[1].
  - Update on each clock edge with ex_branch = 1 and rst_n = 1, indexed and tagged by ex_pc:
    - Hit: counter increments if taken, decrements if not, saturating at 0 and 3; target is rewritten.
    - Miss and taken: allocate with counter = 2'b10 and target = branch target.
    - Miss and not taken: no allocation.
  - The update is written at the clock edge. A same-cycle lookup of the same index sees the old contents.
- PC_BTB_EN undefined:
  - No BTB storage; pred_taken is tied to 0.
  - Every taken branch mispredicts; BTB_DEPTH is unused.

## Test plan
- Reset: RESET_PC = 0x100, rst_n = 0 for 2 cycles with ex_branch = 1, taken → pc = 0x100 and flush outputs = 0 throughout; pc = 0x104 one cycle after release.
- Sequential and stall: free run from 0x0 → pc 0x0, 0x4, 0x8. Then stall = 1 for 3 cycles → pc holds 0x8. After stall drops, pc = 0xC.
- BEQ in EX: ex_pc = 0x20, ex_imm16 = 0xFFFC, ex_zero = 1, ex_pred = 0 → flush_id = flush_ex = 1 that cycle; next pc = 0x14. The same case as BNE (ex_bne = 1) → not taken, no flush, pc advances sequentially.
- Priority: mispredict to 0x200, id_jump (id_instr_index = 0x40, id_pc = 0x30) and stall all in one cycle → next pc = 0x200. Jump alone, no stall → next pc = 0x100 and flush_id = 1, flush_ex = 0.
- BTB (PC_BTB_EN): branch at 0x40 resolved taken to 0x80 once. The next fetch of 0x40 gives pred_taken = 1 and next pc = 0x80. Then resolving that branch not taken with ex_pred = 1 → redirect to 0x44, counter = 2'b01, and the following fetch of 0x40 gives pred_taken = 0.
- Without PC_BTB_EN: repeat the BTB sequence → pred_taken stays 0 and every taken resolution flushes.
